// File: rtl/fwd_select_unit.sv
// fwd_select_unit
//   Forwarding and load-use hazard controller for the pipelined MIPS
//   R-type/load datapath.
//
//   The unit keeps its own shadow copy of the destination metadata for the
//   EX, MEM and WB stages, so the datapath needs no extra wiring. At each
//   rising edge it registers the EX operand mux selects for the instruction
//   that is leaving ID. It also raises a combinational stall when a load in
//   EX feeds the instruction in ID.
//
// Ports
//   clk          pipeline clock; all state updates on the rising edge
//   reset        asynchronous, active-high; clears all state
//   id_valid     a real instruction occupies ID this cycle
//   id_rs        source register 1 of the ID instruction
//   id_rt        source register 2 of the ID instruction
//   id_uses_rt   rt is read as a source (R-type, store)
//   id_reg_write ID instruction writes the register file
//   id_mem_read  ID instruction is a load
//   id_dest      destination register of the ID instruction (after RegDst)
//   fwd_a_sel    EX operand-A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   fwd_b_sel    EX operand-B select, same encoding
//   stall        load-use hazard: hold PC and IF/ID, bubble into EX
//   stall_count  saturating count of stall cycles since reset
module fwd_select_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dest,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_WB  = 2'b01,
    SEL_MEM = 2'b10
  } sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dest;
  } stage_t;

  localparam logic [1:0] EX  = 2'd0;
  localparam logic [1:0] MEM = 2'd1;
  localparam logic [1:0] WB  = 2'd2;

  // Shadow pipeline indexed EX/MEM/WB. WB is kept so the shadow state
  // mirrors the datapath, but it is never consulted: the register file
  // writes in the first half-cycle and reads in the second.
  stage_t           pipe [3];
  stage_t           ex_next;
  sel_e             a_q, b_q, a_d, b_d;
  logic [CNT_W-1:0] cnt_q;

  // A stage produces r only if it really writes and r is not $0.
  function automatic logic writes(input stage_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && (s.dest == r) && (r != '0);
  endfunction

  always_comb begin
    stall = pipe[EX].valid && pipe[EX].mem_read && pipe[EX].reg_write &&
            (pipe[EX].dest != '0) && id_valid &&
            ((pipe[EX].dest == id_rs) ||
             (id_uses_rt && (pipe[EX].dest == id_rt)));
  end

  // Selects are chosen against the stages as they stand now. The EX
  // producer will be in MEM next cycle and MEM will be in WB, so the EX
  // producer is tested first and the newest value wins.
  always_comb begin
    ex_next = '0;
    a_d     = SEL_RF;
    b_d     = SEL_RF;
    if (!stall) begin
      ex_next = {id_valid, id_reg_write, id_mem_read, id_dest};
      if (id_valid) begin
        if (writes(pipe[EX], id_rs))       a_d = SEL_MEM;
        else if (writes(pipe[MEM], id_rs)) a_d = SEL_WB;
        if (id_uses_rt) begin
          if (writes(pipe[EX], id_rt))       b_d = SEL_MEM;
          else if (writes(pipe[MEM], id_rt)) b_d = SEL_WB;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe[EX]  <= '0;
      pipe[MEM] <= '0;
      pipe[WB]  <= '0;
      a_q       <= SEL_RF;
      b_q       <= SEL_RF;
      cnt_q     <= '0;
    end else begin
      pipe[EX]  <= ex_next;
      pipe[MEM] <= pipe[EX];
      pipe[WB]  <= pipe[MEM];
      a_q       <= a_d;
      b_q       <= b_d;
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign fwd_a_sel   = a_q;
  assign fwd_b_sel   = b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_select_unit.sv
// tb_fwd_select_unit
//   Directed bench for fwd_select_unit. Two instances share all inputs:
//   the default 16-bit counter and a 2-bit counter that must saturate at 3.
//   Expected selects are queued when an instruction is driven in ID and are
//   popped when that instruction occupies EX.
module tb_fwd_select_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_reg_write;
  logic       id_mem_read;
  logic [4:0] id_dest;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;
  logic [15:0] stall_count;
  logic [1:0] sat_a, sat_b;
  logic       sat_stall;
  logic [1:0] sat_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t sb [$];

  fwd_select_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
  );

  fwd_select_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .fwd_a_sel(sat_a),
    .fwd_b_sel(sat_b), .stall(sat_stall), .stall_count(sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic rw, input logic mr,
                       input logic [4:0] dst);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_dest      = dst;
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // One ID cycle: check stall while the instruction sits in ID, then check
  // the selects one edge later when it has moved into EX.
  task automatic step(input string tag, input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic rw,
                      input logic mr, input logic [4:0] dst, input logic es,
                      input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    @(negedge clk);
    drive(v, rs, rt, urt, rw, mr, dst);
    #1;
    chk({tag, "/stall"}, stall, es);
    chk({tag, "/sat_stall"}, sat_stall, es);
    sb.push_back('{tag: tag, a: ea, b: eb});
    @(posedge clk);
    if (es) exp_cnt++;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/fwd_a"}, fwd_a_sel, e.a);
      chk({e.tag, "/fwd_b"}, fwd_b_sel, e.b);
      chk({e.tag, "/sat_a"}, sat_a, e.a);
      chk({e.tag, "/sat_b"}, sat_b, e.b);
    end
    chk({tag, "/count"}, stall_count, exp_cnt);
    chk({tag, "/sat_count"}, sat_count, sat3(exp_cnt));
  endtask

  task automatic nop2();
    step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset/a", fwd_a_sel, 2'b00);
    chk("reset/b", fwd_b_sel, 2'b00);
    chk("reset/stall", stall, 0);
    chk("reset/count", stall_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5 -> A from EX/MEM
    step("add3", 1, 1, 2, 1, 1, 0, 3, 0, 2'b00, 2'b00);
    step("sub_a10", 1, 3, 5, 1, 1, 0, 4, 0, 2'b10, 2'b00);
    nop2();

    // add $3 ; nop ; and $6,$7,$3 -> B from MEM/WB
    step("add3", 1, 1, 2, 1, 1, 0, 3, 0, 2'b00, 2'b00);
    step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("and_b01", 1, 7, 3, 1, 1, 0, 6, 0, 2'b00, 2'b01);
    nop2();

    // add $3 ; add $3 ; or $8,$3,$3 -> newest producer wins on both
    step("add3a", 1, 1, 2, 1, 1, 0, 3, 0, 2'b00, 2'b00);
    step("add3b", 1, 1, 2, 1, 1, 0, 3, 0, 2'b00, 2'b00);
    step("or_both10", 1, 3, 3, 1, 1, 0, 8, 0, 2'b10, 2'b10);
    nop2();

    // lw $2 ; add $4,$2,$5 -> one stall then A from MEM/WB
    step("lw2", 1, 1, 2, 0, 1, 1, 2, 0, 2'b00, 2'b00);
    step("add_stall", 1, 2, 5, 1, 1, 0, 4, 1, 2'b00, 2'b00);
    step("add_replay", 1, 2, 5, 1, 1, 0, 4, 0, 2'b01, 2'b00);
    nop2();

    // lw $2 ; addi $2,$7 (rt not a source) -> no stall
    step("lw2", 1, 1, 2, 0, 1, 1, 2, 0, 2'b00, 2'b00);
    step("addi_rt_dest", 1, 7, 2, 0, 1, 0, 2, 0, 2'b00, 2'b00);
    nop2();

    // $0 is never forwarded and never stalls
    step("add0", 1, 1, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    step("sub_r0", 1, 0, 0, 1, 1, 0, 4, 0, 2'b00, 2'b00);
    step("lw0", 1, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00);
    step("add_r0", 1, 0, 0, 1, 1, 0, 4, 0, 2'b00, 2'b00);
    nop2();

    // reset while a stall is being requested
    step("add2", 1, 1, 1, 1, 1, 0, 2, 0, 2'b00, 2'b00);
    step("lw5_a10", 1, 2, 5, 0, 1, 1, 5, 0, 2'b10, 2'b00);
    @(negedge clk);
    drive(1, 5, 6, 1, 1, 0, 4);
    #1;
    chk("pre_rst/stall", stall, 1);
    chk("pre_rst/a", fwd_a_sel, 2'b10);
    chk("pre_rst/count", stall_count, exp_cnt);
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    chk("mid_rst/stall", stall, 0);
    chk("mid_rst/a", fwd_a_sel, 2'b00);
    chk("mid_rst/b", fwd_b_sel, 2'b00);
    chk("mid_rst/count", stall_count, 0);
    chk("mid_rst/sat_count", sat_count, 0);
    chk("mid_rst/sat_stall", sat_stall, 0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 1, 5, 6, 1, 1, 0, 4, 0, 2'b00, 2'b00);

    // five load-use pairs: 16-bit counter reaches 5, 2-bit holds at 3
    for (int k = 0; k < 5; k++) begin
      step("sat_lw", 1, 1, 2, 0, 1, 1, 2, 0, 2'b00, 2'b00);
      step("sat_stall", 1, 2, 5, 1, 1, 0, 4, 1, 2'b00, 2'b00);
      step("sat_replay", 1, 2, 5, 1, 1, 0, 4, 0, 2'b01, 2'b00);
    end
    chk("final/count", stall_count, 5);
    chk("final/sat_count", sat_count, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
